// File: rtl/alu24_sched.sv
// Round-robin scheduler sharing one 24-bit ALU between two requesters.
// Holds registered operands for ALU_LAT cycles, then returns the result (or product as two beats).
module alu24_sched #(
  parameter logic [2:0]  MUL_OP  = 3'b011,
  parameter int unsigned ALU_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [23:0] req0_a,
  input  logic [23:0] req0_b,
  input  logic [2:0]  req0_op,
  input  logic        req0_bneg,
  input  logic [3:0]  req0_shamt,

  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [23:0] req1_a,
  input  logic [23:0] req1_b,
  input  logic [2:0]  req1_op,
  input  logic        req1_bneg,
  input  logic [3:0]  req1_shamt,

  output logic [23:0] alu_a,
  output logic [23:0] alu_b,
  output logic [2:0]  alu_op,
  output logic        alu_bnegate,
  output logic [3:0]  alu_shamt,
  input  logic [23:0] alu_result,
  input  logic [47:0] alu_mul,
  input  logic        alu_zero,
  input  logic        alu_overflow,
  input  logic        alu_carry,

  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [23:0] rsp_data,
  output logic        rsp_last,
  output logic [2:0]  rsp_flags,
  output logic        busy
);

  // state   | meaning
  // IDLE    | arbitrating, ready offered to the round-robin winner
  // EXEC    | ALU operands held, settle counter running
  // RESP_LO | first (or only) response beat presented
  // RESP_HI | upper product half presented
  typedef enum logic [1:0] {IDLE, EXEC, RESP_LO, RESP_HI} state_t;

  localparam logic [3:0] LAT_INIT = 4'(ALU_LAT - 1);

  state_t      state;
  logic [3:0]  cnt;
  logic        last_grant;
  logic [23:0] mul_hi;
  logic        grant0;
  logic        grant1;
  logic        take0;
  logic        take1;

  // A lone valid requester always wins; on contention the one not granted last wins.
  always_comb begin
    grant0 = req0_valid && (!req1_valid || last_grant);
    grant1 = req1_valid && (!req0_valid || !last_grant);
  end

  assign req0_ready = (state == IDLE) && grant0;
  assign req1_ready = (state == IDLE) && grant1;
  assign take0      = req0_valid && req0_ready;
  assign take1      = req1_valid && req1_ready;
  assign busy       = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      last_grant  <= 1'b1;
      mul_hi      <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_op      <= '0;
      alu_bnegate <= 1'b0;
      alu_shamt   <= '0;
      rsp_valid   <= 1'b0;
      rsp_id      <= 1'b0;
      rsp_data    <= '0;
      rsp_last    <= 1'b0;
      rsp_flags   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (take0 || take1) begin
            alu_a       <= take1 ? req1_a     : req0_a;
            alu_b       <= take1 ? req1_b     : req0_b;
            alu_op      <= take1 ? req1_op    : req0_op;
            alu_bnegate <= take1 ? req1_bneg  : req0_bneg;
            alu_shamt   <= take1 ? req1_shamt : req0_shamt;
            rsp_id      <= take1;
            last_grant  <= take1;
            cnt         <= LAT_INIT;
            state       <= EXEC;
          end
        end
        EXEC: begin
          if (cnt == 4'd0) begin
            rsp_flags <= {alu_zero, alu_overflow, alu_carry};
            rsp_valid <= 1'b1;
            if (alu_op == MUL_OP) begin
              rsp_data <= alu_mul[23:0];
              mul_hi   <= alu_mul[47:24];
              rsp_last <= 1'b0;
            end else begin
              rsp_data <= alu_result;
              rsp_last <= 1'b1;
            end
            state <= RESP_LO;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP_LO: begin
          if (rsp_ready) begin
            if (rsp_last) begin
              rsp_valid <= 1'b0;
              state     <= IDLE;
            end else begin
              rsp_data <= mul_hi;
              rsp_last <= 1'b1;
              state    <= RESP_HI;
            end
          end
        end
        RESP_HI: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu24_sched.sv
// Directed bench for alu24_sched: one instance at ALU_LAT=1, a second at ALU_LAT=3.
module tb_alu24_sched;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rsp_ready = 1'b1;

  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic [23:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [2:0]  req0_op = '0, req1_op = '0;
  logic        req0_bneg = 1'b0, req1_bneg = 1'b0;
  logic [3:0]  req0_shamt = '0, req1_shamt = '0;
  logic        req0_ready, req1_ready;
  logic [23:0] alu_a, alu_b;
  logic [2:0]  alu_op;
  logic        alu_bnegate;
  logic [3:0]  alu_shamt;
  logic [74:0] stub_out;
  logic        rsp_valid, rsp_id, rsp_last, busy;
  logic [23:0] rsp_data;
  logic [2:0]  rsp_flags;

  logic        l_req0_valid = 1'b0;
  logic [23:0] l_req0_a = '0, l_req0_b = '0;
  logic        l_req0_ready, l_req1_ready;
  logic [23:0] l_alu_a, l_alu_b;
  logic [2:0]  l_alu_op;
  logic        l_alu_bnegate;
  logic [3:0]  l_alu_shamt;
  logic [74:0] l_stub_out;
  logic        l_rsp_valid, l_rsp_id, l_rsp_last, l_busy;
  logic [23:0] l_rsp_data;
  logic [2:0]  l_rsp_flags;

  int passes = 0;
  int total  = 0;

  always #5 clk = ~clk;

  // ALU stand-in: op 0 = add (with optional B negate), MUL = product, else AND.
  function automatic logic [74:0] alu_stub(input logic [23:0] a, input logic [23:0] b,
                                            input logic [2:0] op, input logic bneg);
    logic [23:0] b_eff;
    logic [24:0] sum;
    logic [47:0] mul;
    logic [23:0] res;
    logic        ovf;
    b_eff = bneg ? (~b + 24'd1) : b;
    sum   = {1'b0, a} + {1'b0, b_eff};
    mul   = {24'd0, a} * {24'd0, b};
    res   = (op == 3'b011) ? mul[23:0] : (op == 3'b000) ? sum[23:0] : (a & b);
    ovf   = (op == 3'b000) && (a[23] == b_eff[23]) && (res[23] != a[23]);
    return {mul, res, (res == 24'd0), ovf, (op == 3'b000) && sum[24]};
  endfunction

  assign stub_out   = alu_stub(alu_a, alu_b, alu_op, alu_bnegate);
  assign l_stub_out = alu_stub(l_alu_a, l_alu_b, l_alu_op, l_alu_bnegate);

  alu24_sched #(.MUL_OP(3'b011), .ALU_LAT(1)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_op(req0_op), .req0_bneg(req0_bneg), .req0_shamt(req0_shamt),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_op(req1_op), .req1_bneg(req1_bneg), .req1_shamt(req1_shamt),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_bnegate(alu_bnegate),
    .alu_shamt(alu_shamt), .alu_result(stub_out[26:3]), .alu_mul(stub_out[74:27]),
    .alu_zero(stub_out[2]), .alu_overflow(stub_out[1]), .alu_carry(stub_out[0]),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .rsp_last(rsp_last), .rsp_flags(rsp_flags), .busy(busy)
  );

  alu24_sched #(.MUL_OP(3'b011), .ALU_LAT(3)) dut3 (
    .clk(clk), .reset(reset),
    .req0_valid(l_req0_valid), .req0_ready(l_req0_ready), .req0_a(l_req0_a), .req0_b(l_req0_b),
    .req0_op(3'b000), .req0_bneg(1'b0), .req0_shamt(4'h0),
    .req1_valid(1'b0), .req1_ready(l_req1_ready), .req1_a(24'd0), .req1_b(24'd0),
    .req1_op(3'b000), .req1_bneg(1'b0), .req1_shamt(4'h0),
    .alu_a(l_alu_a), .alu_b(l_alu_b), .alu_op(l_alu_op), .alu_bnegate(l_alu_bnegate),
    .alu_shamt(l_alu_shamt), .alu_result(l_stub_out[26:3]), .alu_mul(l_stub_out[74:27]),
    .alu_zero(l_stub_out[2]), .alu_overflow(l_stub_out[1]), .alu_carry(l_stub_out[0]),
    .rsp_valid(l_rsp_valid), .rsp_ready(1'b1), .rsp_id(l_rsp_id), .rsp_data(l_rsp_data),
    .rsp_last(l_rsp_last), .rsp_flags(l_rsp_flags), .busy(l_busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (2) tick();
    reset = 1'b0;
    chk("rst_rsp", {rsp_valid, rsp_id, rsp_last, rsp_flags, rsp_data, busy}, 64'd0);
    chk("rst_alu", {alu_a, alu_b, alu_op, alu_bnegate, alu_shamt}, 64'd0);

    // single add from req0
    req0_valid = 1'b1; req0_a = 24'd5; req0_b = 24'd3; req0_op = 3'b000; req0_shamt = 4'hA;
    #1;
    chk("add_ready", {req0_ready, req1_ready}, 64'b10);
    tick();
    req0_valid = 1'b0;
    chk("add_alu", {alu_a, alu_b, alu_op, alu_bnegate, alu_shamt, busy, rsp_valid},
        {24'd5, 24'd3, 3'd0, 1'b0, 4'hA, 1'b1, 1'b0});
    tick();
    chk("add_rsp", {rsp_valid, rsp_id, rsp_last, rsp_flags, rsp_data},
        {1'b1, 1'b0, 1'b1, 3'b000, 24'd8});
    tick();
    chk("add_done", {rsp_valid, busy}, 64'd0);

    // two-beat multiply from req1
    req1_valid = 1'b1; req1_a = 24'hFFFFFF; req1_b = 24'h000002; req1_op = 3'b011;
    req1_shamt = 4'h5;
    #1;
    chk("mul_ready", {req0_ready, req1_ready}, 64'b01);
    tick();
    req1_valid = 1'b0;
    chk("mul_alu", {alu_op, alu_shamt}, {3'b011, 4'h5});
    tick();
    chk("mul_lo", {rsp_valid, rsp_id, rsp_last, rsp_flags, rsp_data},
        {1'b1, 1'b1, 1'b0, 3'b000, 24'hFFFFFE});
    tick();
    chk("mul_hi", {rsp_valid, rsp_id, rsp_last, rsp_flags, rsp_data},
        {1'b1, 1'b1, 1'b1, 3'b000, 24'h000001});
    tick();
    chk("mul_done", {rsp_valid, busy}, 64'd0);

    // zero and carry flags
    req0_valid = 1'b1; req0_a = 24'hFFFFFF; req0_b = 24'd1; req0_op = 3'b000;
    tick();
    req0_valid = 1'b0;
    tick();
    chk("zc_rsp", {rsp_valid, rsp_id, rsp_last, rsp_flags, rsp_data},
        {1'b1, 1'b0, 1'b1, 3'b101, 24'd0});
    tick();

    // reset with a request pending, then both requesters contend
    reset = 1'b1;
    req0_valid = 1'b1; req0_a = 24'd1;  req0_b = 24'd1;  req0_op = 3'b000;
    req1_valid = 1'b1; req1_a = 24'd10; req1_b = 24'd20; req1_op = 3'b000;
    tick();
    reset = 1'b0;
    chk("rr_rst_nolatch", {alu_a, busy}, 64'd0);
    for (int k = 0; k < 4; k++) begin
      chk("rr_grant", {req0_ready, req1_ready}, (k % 2 == 1) ? 64'b01 : 64'b10);
      tick();
      tick();
      chk("rr_rsp", {rsp_valid, rsp_id, rsp_data},
          (k % 2 == 1) ? {1'b1, 1'b1, 24'd30} : {1'b1, 1'b0, 24'd2});
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;

    // backpressure with overflow flag
    rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_a = 24'h7FFFFF; req0_b = 24'd1; req0_op = 3'b000;
    tick();
    req1_valid = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold", {rsp_valid, rsp_id, rsp_last, rsp_flags, rsp_data, req0_ready, req1_ready},
          {1'b1, 1'b0, 1'b1, 3'b010, 24'h800000, 2'b00});
      tick();
    end
    rsp_ready = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
    chk("bp_release", {rsp_valid, rsp_data}, {1'b1, 24'h800000});
    tick();
    chk("bp_done", {rsp_valid, busy}, 64'd0);

    // reset during EXEC of a req1 command
    req1_valid = 1'b1; req1_a = 24'd4; req1_b = 24'd4; req1_op = 3'b000;
    #1;
    chk("rx_ready", {req0_ready, req1_ready}, 64'b01);
    tick();
    reset = 1'b1;
    req0_valid = 1'b1; req0_a = 24'd9; req0_b = 24'd6; req0_op = 3'b000;
    tick();
    chk("rx_flush", {rsp_valid, busy, alu_a, alu_b, alu_op}, 64'd0);
    tick();
    reset = 1'b0;
    chk("rx_nolatch", {rsp_valid, busy, alu_a, alu_b, alu_op, rsp_data}, 64'd0);
    chk("rx_grant", {req0_ready, req1_ready}, 64'b10);
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
    chk("rx_rsp", {rsp_valid, rsp_id, rsp_data}, {1'b1, 1'b0, 24'd15});
    tick();

    // ALU_LAT=3 instance
    l_req0_valid = 1'b1; l_req0_a = 24'h123456; l_req0_b = 24'h111111;
    tick();
    l_req0_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("lat3_hold", {l_alu_a, l_alu_b, l_rsp_valid}, {24'h123456, 24'h111111, 1'b0});
      tick();
    end
    chk("lat3_rsp", {l_rsp_valid, l_rsp_id, l_rsp_last, l_rsp_data},
        {1'b1, 1'b0, 1'b1, 24'h234567});
    tick();
    chk("lat3_done", {l_rsp_valid, l_busy}, 64'd0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

// File: doc/alu24_sched.md
# alu24_sched

Two-port scheduler that shares a single 24-bit ALU between two requesters, typically the instruction pipeline and the address/multiply helper. It arbitrates round-robin, latches the granted command, drives the ALU from registered operands for a programmable settle time, and returns the result over a valid/ready response channel. For multiplication it returns the 48-bit product as two 24-bit beats.

## Interface
- MUL_OP, 3'b011, value of `op` that selects multiply and triggers the two-beat response.
- ALU_LAT, 1, EXEC cycles (range 1..15) the ALU inputs are held before the result is captured.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high.
- reqN_valid  in  1  (N=0,1) command valid.
- reqN_ready  out  1  command accepted this cycle.
- reqN_a  in  24  operand A.
- reqN_b  in  24  operand B.
- reqN_op  in  3  ALU op code, passed through unchanged.
- reqN_bneg  in  1  ALU B-negate, passed through.
- reqN_shamt  in  4  shift amount, passed through.
- alu_a / alu_b  out  24  registered ALU operands.
- alu_op  out  3  registered op.
- alu_bnegate  out  1  registered B-negate.
- alu_shamt  out  4  registered shift amount.
- alu_result  in  24  ALU 24-bit result.
- alu_mul  in  48  ALU product.
- alu_zero, alu_overflow, alu_carry  in  1 each  ALU flags.
- rsp_valid  out  1  response beat valid.
- rsp_ready  in  1  consumer accepts beat.
- rsp_id  out  1  requester index of the response.
- rsp_data  out  24  result or product half.
- rsp_last  out  1  final beat of the response.
- rsp_flags  out  3  {zero, overflow, carry} captured with the result.
- busy  out  1  state != IDLE.

## Operation
- FSM states: IDLE, EXEC, RESP_LO, RESP_HI.
- IDLE: the grant goes to the single valid requester. If both are valid, it goes to the one not granted last. The `last_grant` pointer resets to 1, so req0 wins first. `reqN_ready` is combinational and high only in IDLE, and only for the winner. On a handshake, latch a/b/op/bneg/shamt into the alu_* registers and the index into the id register, set the counter to ALU_LAT-1, and go to EXEC.
- EXEC: hold alu_* stable and decrement the counter each cycle. When the counter is 0, capture the result:
  - rsp_flags ← {alu_zero, alu_overflow, alu_carry}.
  - If op==MUL_OP: rsp_data ← alu_mul[23:0], rsp_last ← 0, and the high half alu_mul[47:24] is latched internally.
  - Otherwise: rsp_data ← alu_result, rsp_last ← 1.
  - Go to RESP_LO.
- RESP_LO: rsp_valid=1.
  - On rsp_ready with last=1, go to IDLE.
  - On rsp_ready with last=0, set rsp_data ← the high half and rsp_last ← 1, and go to RESP_HI.
- RESP_HI: rsp_valid=1. On rsp_ready, go to IDLE.
- Flags are identical on both MUL beats.
- alu_* outputs keep their last values in IDLE. They change only on a command handshake.
- Width rules: operands and results are unsigned bit vectors, with no extension or truncation beyond the product split.
- Pointer update: `last_grant` ← granted index on every command handshake.

## Timing
- Reset values: all alu_* = 0, rsp_valid=0, rsp_data=0, rsp_id=0, rsp_last=0, rsp_flags=0, busy=0, both reqN_ready follow IDLE arbitration, last_grant=1, state=IDLE.
- For a command handshake at edge T:
  - alu_* are valid from cycle T+1.
  - The result is captured at edge T+ALU_LAT.
  - rsp_valid is high from cycle T+ALU_LAT+1.
- Single-beat throughput: at most one op per ALU_LAT+2 cycles with rsp_ready tied high. Add one cycle for MUL.
- While rsp_valid=1 and rsp_ready=0: rsp_data, rsp_id, rsp_last and rsp_flags hold stable, and both reqN_ready=0.
- Requesters may drop valid without a handshake. No command is latched unless ready&valid were both high at the edge.
- Reset in any state returns to reset values on the next edge. An in-flight op and any pending response beat are discarded with no partial response.
- reset and a request in the same cycle: reset wins, and nothing is latched.

## Test plan
- Reset, then req0 {a=5, b=3, op=add code, ALU stub returns a+b} handshakes at T -> rsp_valid at T+2 (ALU_LAT=1), rsp_data=8, rsp_id=0, rsp_last=1, flags={0,0,0}.
- req1 op=MUL_OP, a=0xFFFFFF, b=0x000002 -> beat 1 rsp_data=0xFFFFFE with last=0, then beat 2 rsp_data=0x000001 with last=1, both with id=1.
- req0 and req1 held valid continuously from reset -> grant order 0,1,0,1. Each rsp_id matches its grant, and neither requester waits more than one other command.
- rsp_ready held low for 5 cycles after rsp_valid rises -> rsp_* remain constant, reqN_ready=0 throughout, and the beat completes on the first cycle rsp_ready=1.
- Reset asserted during EXEC of a req1 command -> the next cycle has rsp_valid=0, busy=0, and alu_*=0. No response appears, and with both valid the next grant goes to req0.
- ALU_LAT=3, handshake at T -> alu_* stable over T+1..T+3, and rsp_valid first high at T+4.
